// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor: 2-bit counters plus targets per entry, zero-cycle
// lookup for the fetch PC, EX-stage update, and a saturating mispredict counter.

module bp_entry #(
  parameter int TAG_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             sel,
  input  logic             upd_taken,
  input  logic [TAG_W-1:0] upd_tag,
  input  logic [31:0]      upd_target,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [1:0]       ctr,
  output logic [31:0]      target
);
  logic hit;
  assign hit = valid && (tag == upd_tag);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid  <= 1'b0;
      tag    <= '0;
      ctr    <= 2'b01;
      target <= '0;
    end else if (clr) begin
      valid <= 1'b0;
      ctr   <= 2'b01;
    end else if (sel) begin
      if (hit) begin
        if (upd_taken) begin
          if (ctr != 2'b11) ctr <= ctr + 2'b01;
          target <= upd_target;
        end else if (ctr != 2'b00) begin
          ctr <= ctr - 2'b01;
        end
      end else if (upd_taken) begin
        // Miss on a taken branch: allocate as weakly taken.
        valid  <= 1'b1;
        tag    <= upd_tag;
        target <= upd_target;
        ctr    <= 2'b10;
      end
    end
  end
endmodule

module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          if_pc,
  output logic                 pred_taken,
  output logic [31:0]          pred_target,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic                 upd_taken,
  input  logic [31:0]          upd_target,
  input  logic                 upd_pred_taken,
  input  logic                 bp_clear,
  output logic                 mispredict,
  output logic [CNT_WIDTH-1:0] mispredict_cnt
);
  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = 32 - INDEX_BITS - 2;

  logic [ENTRIES-1:0]            valid_q;
  logic [ENTRIES-1:0][TAG_W-1:0] tag_q;
  logic [ENTRIES-1:0][1:0]       ctr_q;
  logic [ENTRIES-1:0][31:0]      tgt_q;

  logic [INDEX_BITS-1:0] if_idx, upd_idx;
  logic [TAG_W-1:0]      if_tag, upd_tag;
  logic                  if_hit;
  logic                  unused_pc_lsbs;

  assign if_idx  = if_pc[INDEX_BITS+1:2];
  assign if_tag  = if_pc[31:INDEX_BITS+2];
  assign upd_idx = upd_pc[INDEX_BITS+1:2];
  assign upd_tag = upd_pc[31:INDEX_BITS+2];
  assign unused_pc_lsbs = ^upd_pc[1:0];

  for (genvar g = 0; g < ENTRIES; g++) begin : g_ent
    bp_entry #(.TAG_W(TAG_W)) u_ent (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (bp_clear),
      .sel       (upd_valid && (upd_idx == INDEX_BITS'(g))),
      .upd_taken (upd_taken),
      .upd_tag   (upd_tag),
      .upd_target(upd_target),
      .valid     (valid_q[g]),
      .tag       (tag_q[g]),
      .ctr       (ctr_q[g]),
      .target    (tgt_q[g])
    );
  end

  // Lookup reads registered state only, so a same-cycle update is not bypassed.
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + 32'd4;

  assign mispredict = upd_valid && (upd_taken != upd_pred_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mispredict_cnt <= '0;
    else if (mispredict && (mispredict_cnt != '1))
      mispredict_cnt <= mispredict_cnt + 1'b1;
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, randomized run against a
// table model, and hand sequences for counter saturation and mid-run reset.

module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc, upd_pc, upd_target;
  logic        upd_valid, upd_taken, upd_pred_taken, bp_clear;
  logic        pt_a, pt_b, mis_a, mis_b;
  logic [31:0] tg_a, tg_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  branch_predictor #(.INDEX_BITS(6), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pt_a), .pred_target(tg_a),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .bp_clear(bp_clear), .mispredict(mis_a),
    .mispredict_cnt(cnt_a));

  branch_predictor #(.INDEX_BITS(6), .CNT_WIDTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .pred_taken(pt_b), .pred_target(tg_b),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken), .bp_clear(bp_clear), .mispredict(mis_b),
    .mispredict_cnt(cnt_b));

  // Reference model: one record per table slot, counter kept as a plain integer.
  bit          m_valid[64];
  int unsigned m_tag[64];
  int          m_ctr[64];
  logic [31:0] m_tgt[64];
  int          m_cnt;

  typedef struct {
    logic [31:0] if_pc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upred;
    logic        clr;
    logic        e_taken;
    logic [31:0] e_tgt;
    logic        e_mis;
    int          e_cnt;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_ctr[i] = 1; m_tgt[i] = 0;
    end
    m_cnt = 0;
  endtask

  task automatic model_check(input string nm);
    int unsigned idx, tg;
    bit tk;
    logic [31:0] et;
    idx = (if_pc >> 2) % 64;
    tg  = if_pc >> 8;
    tk  = m_valid[idx] && (m_tag[idx] == tg) && (m_ctr[idx] >= 2);
    et  = tk ? m_tgt[idx] : if_pc + 32'd4;
    chk({nm, ".taken"},  {31'd0, pt_a}, {31'd0, tk});
    chk({nm, ".target"}, tg_a, et);
    chk({nm, ".mis"},    {31'd0, mis_a}, {31'd0, upd_valid && (upd_taken != upd_pred_taken)});
    chk({nm, ".cnt16"},  {16'd0, cnt_a}, sat(m_cnt, 65535));
    chk({nm, ".cnt4"},   {28'd0, cnt_b}, sat(m_cnt, 15));
  endtask

  task automatic model_update();
    int unsigned idx, tg;
    idx = (upd_pc >> 2) % 64;
    tg  = upd_pc >> 8;
    if (upd_valid && (upd_taken != upd_pred_taken)) m_cnt++;
    if (bp_clear) begin
      for (int i = 0; i < 64; i++) begin m_valid[i] = 0; m_ctr[i] = 1; end
    end else if (upd_valid) begin
      if (m_valid[idx] && m_tag[idx] == tg) begin
        if (upd_taken) begin
          m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
          m_tgt[idx] = upd_target;
        end else begin
          m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
        end
      end else if (upd_taken) begin
        m_valid[idx] = 1; m_tag[idx] = tg; m_tgt[idx] = upd_target; m_ctr[idx] = 2;
      end
    end
  endtask

  // Check at negedge against the model, then advance model and DUT together.
  task automatic step(input string nm);
    @(negedge clk);
    model_check(nm);
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    upd_pred_taken = 0; bp_clear = 0;
  endtask

  task automatic do_reset();
    drive_idle();
    if_pc = 32'h100;
    rst_n = 0;
    model_reset();
    #3;
    chk("rst.taken",  {31'd0, pt_a}, 32'd0);
    chk("rst.target", tg_a, 32'h104);
    chk("rst.cnt",    {16'd0, cnt_a}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [31:0] p;
    case ($urandom_range(0, 9))
      0:       p = $urandom;
      1:       p = 32'hFFFF_F000 | ($urandom_range(0, 7) << 2);
      default: p = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
    endcase
    return p;
  endfunction

  initial begin
    //          if_pc         uv upc      ut utgt     pr clr  taken tgt           mis cnt
    vt[0]  = '{32'h100,       0, 32'h0,   0, 32'h0,   0, 0,   0, 32'h104,       0, 0};
    vt[1]  = '{32'h100,       1, 32'h100, 1, 32'h80,  0, 0,   0, 32'h104,       1, 0};
    vt[2]  = '{32'h100,       1, 32'h100, 0, 32'h0,   1, 0,   1, 32'h80,        1, 1};
    vt[3]  = '{32'h100,       1, 32'h100, 0, 32'h0,   0, 0,   0, 32'h104,       0, 2};
    vt[4]  = '{32'h100,       0, 32'h0,   0, 32'h0,   0, 0,   0, 32'h104,       0, 2};
    vt[5]  = '{32'h200,       1, 32'h100, 1, 32'h80,  0, 0,   0, 32'h204,       1, 2};
    vt[6]  = '{32'h200,       0, 32'h0,   0, 32'h0,   0, 0,   0, 32'h204,       0, 3};
    vt[7]  = '{32'h100,       1, 32'h100, 1, 32'h90,  0, 0,   0, 32'h104,       1, 3};
    vt[8]  = '{32'h100,       0, 32'h0,   0, 32'h0,   0, 0,   1, 32'h90,        0, 4};
    vt[9]  = '{32'h100,       1, 32'h100, 1, 32'h90,  0, 1,   1, 32'h90,        1, 4};
    vt[10] = '{32'h100,       0, 32'h0,   0, 32'h0,   0, 0,   0, 32'h104,       0, 5};
    vt[11] = '{32'hFFFF_FFFC, 0, 32'h0,   0, 32'h0,   0, 0,   0, 32'h0,         0, 5};
    vt[12] = '{32'h300,       1, 32'h300, 0, 32'h44,  1, 0,   0, 32'h304,       1, 5};
    vt[13] = '{32'h300,       0, 32'h0,   0, 32'h0,   0, 0,   0, 32'h304,       0, 6};

    do_reset();

    for (int i = 0; i < 14; i++) begin
      if_pc = vt[i].if_pc; upd_valid = vt[i].uv; upd_pc = vt[i].upc;
      upd_taken = vt[i].ut; upd_target = vt[i].utgt; upd_pred_taken = vt[i].upred;
      bp_clear = vt[i].clr;
      @(negedge clk);
      chk($sformatf("vec%0d.taken", i),  {31'd0, pt_a}, {31'd0, vt[i].e_taken});
      chk($sformatf("vec%0d.target", i), tg_a, vt[i].e_tgt);
      chk($sformatf("vec%0d.mis", i),    {31'd0, mis_a}, {31'd0, vt[i].e_mis});
      chk($sformatf("vec%0d.cnt", i),    {16'd0, cnt_a}, vt[i].e_cnt);
      @(posedge clk);
      #1;
    end

    // Randomized run against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if_pc          = rnd_pc();
      upd_valid      = ($urandom_range(0, 3) != 0);
      upd_pc         = rnd_pc();
      upd_taken      = $urandom_range(0, 1);
      upd_target     = $urandom & 32'hFFFF_FFFC;
      upd_pred_taken = $urandom_range(0, 1);
      bp_clear       = ($urandom_range(0, 63) == 0);
      step("rnd");
    end

    // Twenty mispredicts: the 4-bit counter must stop at 0xF.
    do_reset();
    for (int n = 0; n < 20; n++) begin
      if_pc = 32'h100; upd_valid = 1; upd_pc = 32'h100; upd_taken = 1;
      upd_target = 32'h80; upd_pred_taken = 0; bp_clear = 0;
      step("sat");
    end
    @(negedge clk);
    chk("sat.cnt4",  {28'd0, cnt_b}, 32'hF);
    chk("sat.cnt16", {16'd0, cnt_a}, 32'd20);
    chk("sat.hit",   {31'd0, pt_a}, 32'd1);

    // Asynchronous reset asserted mid-cycle with a mispredicting update pending.
    #2;
    rst_n = 0;
    #1;
    chk("arst.cnt16",  {16'd0, cnt_a}, 32'd0);
    chk("arst.cnt4",   {28'd0, cnt_b}, 32'd0);
    chk("arst.taken",  {31'd0, pt_a}, 32'd0);
    chk("arst.target", tg_a, 32'h104);
    chk("arst.mis",    {31'd0, mis_a}, 32'd1);
    @(posedge clk);
    #1;
    chk("arst.hold", {16'd0, cnt_a}, 32'd0);
    drive_idle();
    @(negedge clk);
    rst_n = 1;
    model_reset();
    @(posedge clk);
    #1;
    if_pc = 32'h100;
    step("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
